// File: rtl/flow_pkg.sv
// Shared types and default widths for the flow framer.
package flow_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefLenWidth  = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/flow_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module flow_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/flow_framer.sv
// Cuts a continuous sample stream into frames of frame_len samples with a tlast marker.
// Define FLOW_FRAMER_STATS_EN to build the frame/drop counters; otherwise they read 0.
module flow_framer
  import flow_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefDataWidth,
  parameter int unsigned LENWIDTH  = DefLenWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_tvalid,
  input  logic                 enable,
  input  logic [LENWIDTH-1:0]  frame_len,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_tvalid,
  output logic                 dout_tlast,
  output logic                 busy,
  output logic [31:0]          frame_count,
  output logic [31:0]          drop_count
);

  state_t                state_q, state_d;
  logic [LENWIDTH-1:0]   len_q, len_d;
  logic [LENWIDTH-1:0]   idx_q, idx_d;
  logic [DATAWIDTH-1:0]  dout_q, dout_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  last_hit;
  logic                  start_ok;

  assign last_hit = (idx_q == (len_q - 1'b1));
  assign start_ok = enable && (frame_len != '0);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    dout_d   = '0;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          len_d   = frame_len;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (din_tvalid) begin
          dout_d   = din;
          tvalid_d = 1'b1;
          if (last_hit) begin
            tlast_d = 1'b1;
            idx_d   = '0;
            // Back-to-back frames re-latch the length; otherwise fall back to idle.
            if (start_ok) begin
              len_d = frame_len;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      dout_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign dout        = dout_q;
  assign dout_tvalid = tvalid_q;
  assign dout_tlast  = tlast_q;
  assign busy        = (state_q == RUN);

`ifdef FLOW_FRAMER_STATS_EN
  logic frame_inc;
  logic drop_inc;

  assign frame_inc = (state_q == RUN) && din_tvalid && last_hit;
  assign drop_inc  = (state_q == IDLE) && din_tvalid;

  flow_sat_cnt u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_inc),
    .cnt (frame_count)
  );

  flow_sat_cnt u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (drop_count)
  );
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_flow_framer.sv
// Directed self-checking bench for flow_framer (counter checks track FLOW_FRAMER_STATS_EN).
module tb_flow_framer;

`ifdef FLOW_FRAMER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [63:0] din;
  logic        din_tvalid;
  logic        enable;
  logic [15:0] frame_len;
  logic [63:0] dout;
  logic        dout_tvalid;
  logic        dout_tlast;
  logic        busy;
  logic [31:0] frame_count;
  logic [31:0] drop_count;

  int unsigned err_cnt;
  int unsigned chk_cnt;

  flow_framer u_dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_tvalid  (din_tvalid),
    .enable      (enable),
    .frame_len   (frame_len),
    .dout        (dout),
    .dout_tvalid (dout_tvalid),
    .dout_tlast  (dout_tlast),
    .busy        (busy),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] st(input int unsigned n);
    return StatsEn ? 64'(n) : 64'd0;
  endfunction

  // Outputs are looked at 1 ns after the edge that consumed the inputs.
  task automatic drive(input logic v, input logic [63:0] d);
    din_tvalid = v;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                           input logic last);
    check_val({tag, ".tvalid"}, 64'(dout_tvalid), 64'(v));
    check_val({tag, ".dout"}, dout, v ? d : 64'd0);
    check_val({tag, ".tlast"}, 64'(dout_tlast), 64'(last));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    din_tvalid = 1'b0;
    din        = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    frame_len = '0;

    // Reset state
    do_reset();
    check_out("rst", 1'b0, 64'd0, 1'b0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.frames", 64'(frame_count), 64'd0);
    check_val("rst.drops", 64'(drop_count), 64'd0);

    // Two contiguous 4-sample frames
    frame_len = 16'd4;
    enable    = 1'b1;
    drive(1'b0, 64'd0);
    check_val("f4.busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      enable = (i != 8);
      drive(1'b1, 64'(i));
      check_out($sformatf("f4.s%0d", i), 1'b1, 64'(i), (i % 4) == 0);
    end
    check_val("f4.frames", 64'(frame_count), st(2));
    check_val("f4.drops", 64'(drop_count), st(0));
    check_val("f4.idle", 64'(busy), 64'd0);

    // Gapped input: idx holds across invalid cycles
    do_reset();
    frame_len = 16'd3;
    enable    = 1'b1;
    drive(1'b0, 64'd0);
    enable = 1'b0;
    drive(1'b1, 64'h10); check_out("gap.0", 1'b1, 64'h10, 1'b0);
    drive(1'b0, 64'hAA); check_out("gap.1", 1'b0, 64'h0, 1'b0);
    drive(1'b1, 64'h11); check_out("gap.2", 1'b1, 64'h11, 1'b0);
    drive(1'b0, 64'hBB); check_out("gap.3", 1'b0, 64'h0, 1'b0);
    drive(1'b1, 64'h12); check_out("gap.4", 1'b1, 64'h12, 1'b1);
    check_val("gap.frames", 64'(frame_count), st(1));
    check_val("gap.busy", 64'(busy), 64'd0);

    // Enable dropped mid-frame; transition-cycle sample is dropped
    do_reset();
    frame_len = 16'd5;
    enable    = 1'b1;
    drive(1'b1, 64'd99);
    check_out("en.trans", 1'b0, 64'd0, 1'b0);
    check_val("en.busy0", 64'(busy), 64'd1);
    check_val("en.drop0", 64'(drop_count), st(1));
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) enable = 1'b0;
      drive(1'b1, 64'(i));
      check_out($sformatf("en.s%0d", i), 1'b1, 64'(i), i == 5);
    end
    check_val("en.busy1", 64'(busy), 64'd0);
    drive(1'b1, 64'd6); check_out("en.d6", 1'b0, 64'd0, 1'b0);
    drive(1'b1, 64'd7); check_out("en.d7", 1'b0, 64'd0, 1'b0);
    check_val("en.drops", 64'(drop_count), st(3));
    check_val("en.frames", 64'(frame_count), st(1));

    // frame_len changed 4 -> 2 mid-frame
    do_reset();
    frame_len = 16'd4;
    enable    = 1'b1;
    drive(1'b0, 64'd0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) frame_len = 16'd2;
      if (i == 6) enable = 1'b0;
      drive(1'b1, 64'(i + 32));
      check_out($sformatf("len.s%0d", i), 1'b1, 64'(i + 32), (i == 4) || (i == 6));
    end
    check_val("len.frames", 64'(frame_count), st(2));
    check_val("len.busy", 64'(busy), 64'd0);

    // frame_len=1: every sample is last; frame_len=0: never starts
    do_reset();
    frame_len = 16'd1;
    enable    = 1'b1;
    drive(1'b0, 64'd0);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) enable = 1'b0;
      drive(1'b1, 64'(i + 64));
      check_out($sformatf("one.s%0d", i), 1'b1, 64'(i + 64), 1'b1);
    end
    check_val("one.frames", 64'(frame_count), st(3));
    frame_len = 16'd0;
    enable    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(i + 1));
      check_out($sformatf("zero.s%0d", i), 1'b0, 64'd0, 1'b0);
      check_val($sformatf("zero.busy%0d", i), 64'(busy), 64'd0);
    end
    check_val("zero.drops", 64'(drop_count), st(3));

    // Reset mid-frame discards the partial frame, then a clean restart
    do_reset();
    frame_len = 16'd4;
    enable    = 1'b1;
    drive(1'b0, 64'd0);
    drive(1'b1, 64'd1);
    drive(1'b1, 64'd2);
    rst = 1'b1;
    drive(1'b1, 64'd3);
    rst = 1'b0;
    check_out("mrst", 1'b0, 64'd0, 1'b0);
    check_val("mrst.busy", 64'(busy), 64'd0);
    check_val("mrst.frames", 64'(frame_count), 64'd0);
    check_val("mrst.drops", 64'(drop_count), 64'd0);
    drive(1'b0, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) enable = 1'b0;
      drive(1'b1, 64'(i + 100));
      check_out($sformatf("rs.s%0d", i), 1'b1, 64'(i + 100), i == 4);
    end
    check_val("rs.frames", 64'(frame_count), st(1));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/flow_framer.md
FLOW_FRAMER -- requirements
Module: flow_framer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 64, sample width in bits.
REQ-002 SHALL have parameter LENWIDTH, default 16, width of the frame-length field.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  DATAWIDTH  continuous sample stream, opaque data.
REQ-006 SHALL have port din_tvalid  input  1  din qualifier.
REQ-007 SHALL have port enable  input  1  framing run request.
REQ-008 SHALL have port frame_len  input  LENWIDTH  samples per frame, sampled only at frame boundaries.
REQ-009 SHALL have port dout  output  DATAWIDTH  framed sample; 0 when dout_tvalid=0.
REQ-010 SHALL have port dout_tvalid  output  1  dout qualifier.
REQ-011 SHALL have port dout_tlast  output  1  last sample of frame; asserted only with dout_tvalid=1.
REQ-012 SHALL have port busy  output  1  high while state=RUN.
REQ-013 SHALL have port frame_count  output  32  completed frames.
REQ-014 SHALL have port drop_count  output  32  valid samples discarded outside RUN.

Function
REQ-015 SHALL implement states IDLE and RUN, plus a registered length len_reg and a sample index idx (LENWIDTH bits).
REQ-016 IDLE->RUN SHALL occur when enable=1 and frame_len!=0; len_reg<=frame_len, idx<=0.
REQ-017 A din_tvalid=1 sample in IDLE, including the transition cycle, SHALL be dropped; drop_count+1.
REQ-018 In RUN, every din_tvalid=1 sample SHALL appear on dout with dout_tvalid=1 exactly one cycle later (latency 1, registered).
REQ-019 In RUN, din_tvalid=0 cycles SHALL produce dout=0 and dout_tvalid=0 one cycle later, and idx SHALL hold.
REQ-020 A valid sample with idx==len_reg-1 SHALL produce dout_tlast=1 on its output cycle, idx<=0, frame_count+1.
REQ-021 At that boundary, if enable=1 and frame_len!=0, then len_reg<=frame_len and state stays RUN; the next sample may arrive the following cycle with no gap.
REQ-022 At that boundary, if enable=0 or frame_len==0, then state<=IDLE.
REQ-023 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes to len_reg samples.
REQ-024 Changing frame_len mid-frame SHALL have no effect until the next boundary.
REQ-025 len_reg==1 SHALL mark every valid sample with dout_tlast=1.
REQ-026 frame_count and drop_count SHALL saturate at 32'hFFFFFFFF with no wrap.
REQ-027 idx compare SHALL use full LENWIDTH; max frame is 2^LENWIDTH-1 samples.

Reset
REQ-028 rst=1 SHALL set state=IDLE, len_reg=0, idx=0, dout=0, dout_tvalid=0, dout_tlast=0, busy=0, frame_count=0, drop_count=0 on the next edge.
REQ-029 rst mid-frame SHALL discard the partial frame; no dout_tlast is emitted for it.
REQ-030 rst SHALL take priority over all inputs in the same cycle.

Configuration
REQ-031 Macro FLOW_FRAMER_STATS_EN SHALL compile in the frame_count/drop_count counters.
REQ-032 When FLOW_FRAMER_STATS_EN is undefined, frame_count and drop_count SHALL remain present as ports, tied to 0, with no counter logic; all other behaviour is unchanged.

Structure
REQ-033 Package flow_pkg SHALL hold the state typedef (IDLE, RUN) and the default DATAWIDTH/LENWIDTH constants.
REQ-034 The saturating counter SHALL be sub-module flow_sat_cnt (32 bit, inc, rst), instantiated twice.
REQ-035 Outputs SHALL connect directly to the downstream per-frame max stage: dout->din, dout_tvalid->din_tvalid, dout_tlast->din_tlast.

Verification
REQ-036 frame_len=4, enable=1, 8 contiguous valid samples 1..8 -> dout 1..8, tlast on 4 and 8, frame_count=2, drop_count=0.
REQ-037 frame_len=3 with din_tvalid toggling 1,0,1,0,1 -> 3 outputs, tlast only on the third valid sample, idx holds across gaps.
REQ-038 enable dropped after sample 2 of a 5-sample frame -> samples 3..5 still emitted, tlast on 5, busy=0 the cycle after; following valid samples dropped, drop_count increments.
REQ-039 frame_len changed 4->2 mid-frame -> current frame is 4 long, next frame is 2 long.
REQ-040 frame_len=1 -> every output carries tlast; frame_len=0 with enable=1 -> stays IDLE, all valid samples dropped.
REQ-041 rst on sample 3 of a 4-sample frame -> all outputs 0 next cycle, no tlast, counters 0; restart yields a full 4-sample frame.
